// File: rtl/subleq_ctrl.sv
// ============================================================================
// Module      : subleq_ctrl
// Description : Sequencing controller for a SUBLEQ core. It fetches A, B and C,
//               reads both operands, writes mem[B] = mem[B] - mem[A] and
//               branches to C when the result is <= 0. C == all-ones halts.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subleq_ctrl #(
    parameter int WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic                 run,
    input  logic [WORD_SIZE-1:0] pc,
    output logic                 pc_branch,
    output logic                 pc_inc,
    output logic [WORD_SIZE-1:0] pc_addr,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 halted
);

    typedef enum logic [2:0] {
        S_FETCH_A = 3'd0,
        S_FETCH_B = 3'd1,
        S_FETCH_C = 3'd2,
        S_READ_A  = 3'd3,
        S_READ_B  = 3'd4,
        S_WRITE   = 3'd5,
        S_BRANCH  = 3'd6,
        S_HALT    = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    // Each memory state spends one idle cycle (r_busy low) before requesting,
    // which guarantees the mandatory req-low gap between transactions.
    logic                 r_busy;
    logic                 w_busy_nxt;
    logic [WORD_SIZE-1:0] r_a, r_b, r_c, r_va, r_vb;
    logic [WORD_SIZE-1:0] w_result;
    logic                 w_le;
    logic                 w_is_mem;
    logic                 w_ack;

    assign w_result = r_vb - r_va;
    assign w_le     = (w_result == '0) || w_result[WORD_SIZE-1];
    assign w_is_mem = (r_state != S_BRANCH) && (r_state != S_HALT);
    assign w_ack    = w_is_mem && r_busy && mem_ack;

    always_ff @(posedge clk) begin
        if (areset) begin
            r_state <= S_FETCH_A;
            r_busy  <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_va    <= '0;
            r_vb    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            if (w_ack) begin
                case (r_state)
                    S_FETCH_A: r_a  <= mem_rdata;
                    S_FETCH_B: r_b  <= mem_rdata;
                    S_FETCH_C: r_c  <= mem_rdata;
                    S_READ_A:  r_va <= mem_rdata;
                    S_READ_B:  r_vb <= mem_rdata;
                    default:   ;
                endcase
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = r_busy;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        pc_inc      = 1'b0;
        pc_branch   = 1'b0;
        pc_addr     = '0;
        halted      = 1'b0;

        if (w_is_mem) begin
            mem_req = r_busy;
            if (!r_busy) begin
                w_busy_nxt = (r_state != S_FETCH_A) || run;
            end else if (mem_ack) begin
                w_busy_nxt = 1'b0;
            end
        end

        case (r_state)
            S_FETCH_A: begin
                mem_addr = pc;
                pc_inc   = w_ack;
                if (w_ack) w_state_nxt = S_FETCH_B;
            end
            S_FETCH_B: begin
                mem_addr = pc;
                pc_inc   = w_ack;
                if (w_ack) w_state_nxt = S_FETCH_C;
            end
            S_FETCH_C: begin
                mem_addr = pc;
                pc_inc   = w_ack;
                if (w_ack) w_state_nxt = S_READ_A;
            end
            S_READ_A: begin
                mem_addr = r_a;
                if (w_ack) w_state_nxt = S_READ_B;
            end
            S_READ_B: begin
                mem_addr = r_b;
                if (w_ack) w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                mem_addr  = r_b;
                mem_wdata = w_result;
                mem_we    = r_busy;
                if (w_ack) w_state_nxt = S_BRANCH;
            end
            S_BRANCH: begin
                if (w_le && (r_c == '1)) begin
                    w_state_nxt = S_HALT;
                end else begin
                    w_state_nxt = S_FETCH_A;
                    if (w_le) begin
                        pc_branch = 1'b1;
                        pc_addr   = r_c;
                    end
                end
            end
            default: begin
                halted = 1'b1;
            end
        endcase

        // Reset wins over everything, including the outputs of the cycle it is asserted in.
        if (areset) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            pc_inc    = 1'b0;
            pc_branch = 1'b0;
            pc_addr   = '0;
            halted    = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_subleq_ctrl.sv
// ============================================================================
// Module      : tb_subleq_ctrl
// Description : Self-checking bench for subleq_ctrl with a memory/PC model and
//               an instruction-level SUBLEQ reference.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_subleq_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         areset = 1'b1;
    logic         run = 1'b0;
    logic [W-1:0] pc = '0;
    logic         pc_branch, pc_inc, mem_req, mem_we, halted;
    logic [W-1:0] pc_addr, mem_addr, mem_wdata, mem_rdata;
    logic         mem_ack;

    logic [W-1:0] mem [0:255];
    logic [W-1:0] ref_mem [0:255];
    logic [W-1:0] ref_pc;
    bit           rand_mode = 1'b0;
    bit           force_ack = 1'b0;
    bit           spur = 1'b0;
    bit           mon_en = 1'b0;
    int           wait_cnt = 0;
    int           cur_delay = 0;
    int           txn_count = 0;
    int           checks = 0;
    int           errors = 0;

    subleq_ctrl #(.WORD_SIZE(W)) dut (
        .clk(clk), .areset(areset), .run(run), .pc(pc),
        .pc_branch(pc_branch), .pc_inc(pc_inc), .pc_addr(pc_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // Memory responder: ack after cur_delay cycles of req; random acks while idle.
    always_comb begin
        mem_rdata = mem[mem_addr];
        if (force_ack)    mem_ack = 1'b1;
        else if (mem_req) mem_ack = (wait_cnt >= cur_delay);
        else              mem_ack = spur;
    end

    always @(posedge clk) begin
        if (mem_req && mem_ack) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            wait_cnt  <= 0;
            cur_delay <= rand_mode ? int'($urandom_range(0, 3)) : 0;
            txn_count <= txn_count + 1;
        end else if (mem_req) begin
            wait_cnt <= wait_cnt + 1;
        end else begin
            wait_cnt <= 0;
        end
        spur <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
        if (areset)         pc <= '0;
        else if (pc_branch) pc <= pc_addr;
        else if (pc_inc)    pc <= pc + 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshake protocol monitor, sampled mid-cycle.
    logic         p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
    logic [W-1:0] p_addr = '0, p_wdata = '0;
    always @(negedge clk) begin
        if (mon_en && !areset) begin
            if (p_req && !p_ack)
                chk("hold_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, p_we, p_addr, p_wdata});
            if (p_req && p_ack)
                chk("req_gap", 32'(mem_req), 32'd0);
            if (pc_inc || pc_branch)
                chk("inc_branch_excl", 32'(pc_inc & pc_branch), 32'd0);
            if (halted)
                chk("halt_no_req", {mem_req, pc_inc, pc_branch}, 32'd0);
        end
        p_req = mem_req && !areset; p_ack = mem_ack; p_we = mem_we;
        p_addr = mem_addr; p_wdata = mem_wdata;
    end

    task automatic do_reset();
        @(posedge clk); #1;
        areset = 1'b1; run = 1'b0;
        @(posedge clk); #1;
        areset = 1'b0;
    endtask

    task automatic load_instr(input logic [W-1:0] a, b, c, va, vb);
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0] = a; mem[1] = b; mem[2] = c; mem[a] = va; mem[b] = vb;
    endtask

    // Runs until the cycle after the write ack (the BRANCH cycle) has completed.
    task automatic exec_instr(output int cyc, output int incs, output int brs,
                              output logic [W-1:0] baddr, output bit ok);
        bit wdone = 1'b0;
        cyc = 0; incs = 0; brs = 0; baddr = '0; ok = 1'b0;
        while (cyc < 300) begin
            @(negedge clk);
            if (pc_inc) incs++;
            if (pc_branch) begin brs++; baddr = pc_addr; end
            if (wdone) begin
                @(posedge clk); #1; cyc++; ok = 1'b1;
                break;
            end
            if (mem_req && mem_we && mem_ack) wdone = 1'b1;
            @(posedge clk); #1; cyc++;
        end
        chk("instr_timeout", 32'(ok), 32'd1);
    endtask

    task automatic ref_step(output bit halt);
        logic [W-1:0] a, b, c, va, vb, r;
        a = ref_mem[ref_pc]; b = ref_mem[ref_pc + 8'd1]; c = ref_mem[ref_pc + 8'd2];
        va = ref_mem[a]; vb = ref_mem[b]; r = vb - va;
        ref_mem[b] = r;
        halt = 1'b0;
        if ($signed(r) <= 0) begin
            if (c == 8'hFF) begin halt = 1'b1; ref_pc = ref_pc + 8'd3; end
            else ref_pc = c;
        end else begin
            ref_pc = ref_pc + 8'd3;
        end
    endtask

    task automatic cmp_mem(input string tag);
        int diffs = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk(tag, 32'(diffs), 32'd0);
    endtask

    int           cyc, incs, brs, n0;
    logic [W-1:0] baddr;
    bit           ok, rhalt;

    initial begin
        // Reset state, checked while reset is asserted and just after release.
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_outputs", {mem_req, mem_we, pc_inc, pc_branch, halted, pc_addr, mem_addr, mem_wdata},
            32'd0);
        do_reset();
        mon_en = 1'b1;
        @(negedge clk);
        chk("post_rst_outputs", {mem_req, mem_we, pc_inc, pc_branch, halted, pc_addr, mem_addr, mem_wdata},
            32'd0);

        // Idle in FETCH_A while run is low.
        load_instr(8'd10, 8'd11, 8'd6, 8'd3, 8'd5);
        repeat (4) @(posedge clk); #1;
        chk("idle_no_req", 32'(mem_req), 32'd0);

        // Positive result: no branch, 13 cycles.
        run = 1'b1;
        exec_instr(cyc, incs, brs, baddr, ok);
        chk("pos_result", 32'(mem[11]), 32'd2);
        chk("pos_cycles", 32'(cyc), 32'd13);
        chk("pos_incs", 32'(incs), 32'd3);
        chk("pos_nobranch", 32'(brs), 32'd0);
        chk("pos_pc", 32'(pc), 32'd3);

        // Zero result: branch to C.
        do_reset();
        load_instr(8'd10, 8'd11, 8'd6, 8'd5, 8'd5);
        run = 1'b1;
        exec_instr(cyc, incs, brs, baddr, ok);
        chk("zero_result", 32'(mem[11]), 32'd0);
        chk("zero_branch", 32'(brs), 32'd1);
        chk("zero_baddr", 32'(baddr), 32'd6);
        chk("zero_pc", 32'(pc), 32'd6);

        // Wrap: 0x80 - 1 = 0x7F is positive.
        do_reset();
        load_instr(8'd10, 8'd11, 8'd6, 8'd1, 8'h80);
        run = 1'b1;
        exec_instr(cyc, incs, brs, baddr, ok);
        chk("wrap_result", 32'(mem[11]), 32'h7F);
        chk("wrap_nobranch", 32'(brs), 32'd0);
        chk("wrap_pc", 32'(pc), 32'd3);

        // Halt on C == 0xFF with le.
        do_reset();
        load_instr(8'd10, 8'd11, 8'hFF, 8'd1, 8'd1);
        run = 1'b1;
        exec_instr(cyc, incs, brs, baddr, ok);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_nobranch", 32'(brs), 32'd0);
        chk("halt_pc", 32'(pc), 32'd3);
        n0 = txn_count;
        repeat (20) @(posedge clk); #1;
        chk("halt_terminal", {31'(txn_count - n0), halted}, 32'd1);
        do_reset();
        @(negedge clk);
        chk("halt_cleared", 32'(halted), 32'd0);

        // Reset during READ_B with ack pending, then a late ack.
        load_instr(8'd10, 8'd11, 8'd6, 8'd3, 8'd5);
        for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
        cur_delay = 6;
        n0 = txn_count;
        run = 1'b1;
        for (int i = 0; i < 200 && !(txn_count == n0 + 4 && mem_req); i++) begin
            @(posedge clk); #1;
            if (txn_count != n0 + 4) cur_delay = (txn_count == n0 + 3) ? 6 : 0;
        end
        chk("readb_reached", {mem_req, mem_addr}, {1'b1, 8'd11});
        mon_en = 1'b0;
        areset = 1'b1; run = 1'b0; force_ack = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        @(negedge clk);
        chk("abort_outputs", {mem_req, mem_we, pc_inc, pc_branch, halted, pc_addr, mem_addr, mem_wdata},
            32'd0);
        @(posedge clk); #1;
        force_ack = 1'b0; cur_delay = 0;
        cmp_mem("abort_mem");
        mon_en = 1'b1;
        run = 1'b1;
        exec_instr(cyc, incs, brs, baddr, ok);
        chk("abort_restart_cycles", 32'(cyc), 32'd13);
        chk("abort_restart_result", 32'(mem[11]), 32'd2);

        // Random programs with random ack delays and idle-time spurious acks.
        rand_mode = 1'b1;
        for (int t = 0; t < 20; t++) begin
            do_reset();
            for (int i = 0; i < 256; i++) begin
                mem[i] = 8'($urandom);
                ref_mem[i] = mem[i];
            end
            ref_pc = '0;
            run = 1'b1;
            for (int k = 0; k < 8; k++) begin
                exec_instr(cyc, incs, brs, baddr, ok);
                ref_step(rhalt);
                cmp_mem("rand_mem");
                chk("rand_pc", 32'(pc), 32'(ref_pc));
                chk("rand_halt", 32'(halted), 32'(rhalt));
                if (rhalt || !ok) break;
            end
        end
        rand_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
